// File: rtl/mtr_pwm_drv.sv
// Dual complementary PWM driver for the left/right wheel H-bridges, 2048-clock period with dead time.
// Latency: a speed command latched at cnt==2047 governs the period starting at the next cnt==0.
// Backpressure: none; free-running, and inputs are sampled only at the latch point.
// Optional: define MTR_SLEW_EN to limit the latched duty change to SLEW per period.
module mtr_pwm_drv #(
  parameter int NONOVERLAP = 32,
  parameter int SLEW       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2,
  output logic        upd
);

  // Elaboration-time guard on the parameter ranges.
  if (NONOVERLAP < 1 || NONOVERLAP > 127) begin : g_bad_nonoverlap
    $error("mtr_pwm_drv: NONOVERLAP must be 1..127");
  end
  if (SLEW < 1 || SLEW > 1023) begin : g_bad_slew
    $error("mtr_pwm_drv: SLEW must be 1..1023");
  end

  localparam logic [10:0] NO11 = 11'(NONOVERLAP);
  localparam logic [11:0] NO12 = 12'(NONOVERLAP);
  localparam logic [10:0] CNT_LAST = 11'h7FF;

  logic [10:0] cnt;
  logic [10:0] lft_d, rght_d;
  logic [10:0] lft_tgt, rght_tgt;
  logic [10:0] lft_nxt, rght_nxt;
  logic        latch;

  // Signed-to-offset: adding 0x400 maps -1024..1023 onto 0..2047 with no saturation.
  assign lft_tgt  = lft_spd + 11'h400;
  assign rght_tgt = rght_spd + 11'h400;
  assign latch    = (cnt == CNT_LAST);

`ifdef MTR_SLEW_EN
  localparam logic signed [11:0] SLEW_S = 12'(SLEW);
  localparam logic [10:0]        SLEW_U = 11'(SLEW);

  // Move d toward the target by at most SLEW; the last step lands exactly on the target.
  function automatic logic [10:0] slew_step(input logic [10:0] d, input logic [10:0] tgt);
    logic signed [11:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, d});
    if (diff > SLEW_S)
      slew_step = d + SLEW_U;
    else if (diff < -SLEW_S)
      slew_step = d - SLEW_U;
    else
      slew_step = tgt;
  endfunction

  assign lft_nxt  = slew_step(lft_d, lft_tgt);
  assign rght_nxt = slew_step(rght_d, rght_tgt);
`else
  assign lft_nxt  = lft_tgt;
  assign rght_nxt = rght_tgt;
`endif

  // Registered set/clear flop: clear has priority over set.
  function automatic logic sr_nxt(input logic q, input logic set, input logic clr);
    if (clr)
      sr_nxt = 1'b0;
    else if (set)
      sr_nxt = 1'b1;
    else
      sr_nxt = q;
  endfunction

  // PWM1 rises after the dead time following cnt==0, only if the duty leaves a non-empty pulse.
  function automatic logic set1(input logic [10:0] c, input logic [10:0] d);
    set1 = (c == NO11) && (d > NO11);
  endfunction

  // PWM2 rises a dead time after d; 12-bit compare so d+NONOVERLAP never wraps into a false match.
  function automatic logic set2(input logic [10:0] c, input logic [10:0] d);
    logic [11:0] edge12;
    edge12 = {1'b0, d} + NO12;
    set2   = ({1'b0, c} == edge12) && (edge12 < 12'd2047);
  endfunction

  // Shared period counter, latched duties and the update strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 11'd0;
      lft_d  <= 11'h400;
      rght_d <= 11'h400;
      upd    <= 1'b0;
    end else begin
      cnt <= cnt + 11'd1;
      upd <= latch;
      if (latch) begin
        lft_d  <= lft_nxt;
        rght_d <= rght_nxt;
      end
    end
  end

  // Left motor output pair, evaluated against the currently latched duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lftPWM1 <= 1'b0;
      lftPWM2 <= 1'b0;
    end else begin
      lftPWM1 <= sr_nxt(lftPWM1, set1(cnt, lft_d), cnt == lft_d);
      lftPWM2 <= sr_nxt(lftPWM2, set2(cnt, lft_d), latch);
    end
  end

  // Right motor output pair, same timing as the left one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rghtPWM1 <= 1'b0;
      rghtPWM2 <= 1'b0;
    end else begin
      rghtPWM1 <= sr_nxt(rghtPWM1, set1(cnt, rght_d), cnt == rght_d);
      rghtPWM2 <= sr_nxt(rghtPWM2, set2(cnt, rght_d), latch);
    end
  end

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Directed bench for mtr_pwm_drv: per-period high-time counts, dead-time overlap, upd spacing, reset.
// Samples on the falling edge; sample index 0 of a period is the cycle in which upd is high (cnt==0).
// Build with MTR_SLEW_EN defined to exercise the slew-limited ramp instead of the step tests.
module tb_mtr_pwm_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, upd;

  int n_cmp = 0;
  int n_bad = 0;

  int l1, l2, r1, r2, ovl, nupd, wt;

  always #5 clk = ~clk;

  mtr_pwm_drv #(.NONOVERLAP(32), .SLEW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .lftPWM1  (lftPWM1),
    .lftPWM2  (lftPWM2),
    .rghtPWM1 (rghtPWM1),
    .rghtPWM2 (rghtPWM2),
    .upd      (upd)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Wait for the next upd, then count high cycles of each output over one full period.
  // Optionally drives lft_spd at sample index chg_idx within the period.
  task automatic measure(input int chg_idx, input logic [10:0] chg_val);
    wt = 0;
    do begin
      @(negedge clk);
      wt++;
    end while (!upd && wt < 4200);
    if (!upd) chk("upd_timeout", 0, 1);
    l1 = 0; l2 = 0; r1 = 0; r2 = 0; ovl = 0; nupd = 0;
    for (int i = 0; i < 2048; i++) begin
      if (i > 0) @(negedge clk);
      if (i == chg_idx) lft_spd = chg_val;
      l1   += int'(lftPWM1);
      l2   += int'(lftPWM2);
      r1   += int'(rghtPWM1);
      r2   += int'(rghtPWM2);
      ovl  += int'((lftPWM1 & lftPWM2) | (rghtPWM1 & rghtPWM2));
      nupd += int'(upd);
    end
  endtask

  task automatic check_period(input string tag, input int el1, input int el2,
                              input int er1, input int er2);
    chk({tag, "_l1"}, l1, el1);
    chk({tag, "_l2"}, l2, el2);
    chk({tag, "_r1"}, r1, er1);
    chk({tag, "_r2"}, r2, er2);
    chk({tag, "_ovl"}, ovl, 0);
    chk({tag, "_nupd"}, nupd, 1);
  endtask

  // Release reset on a falling edge and time the first PWM1 rises and the first upd.
  task automatic fresh_start(input string tag);
    int rise_l, rise_r, upd_k, pwm2_early;
    rise_l = -1; rise_r = -1; upd_k = -1; pwm2_early = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 2200 && upd_k < 0; k++) begin
      @(negedge clk);
      if (lftPWM1 && rise_l < 0) rise_l = k;
      if (rghtPWM1 && rise_r < 0) rise_r = k;
      if (k <= 33) pwm2_early += int'(lftPWM2 | rghtPWM2);
      if (upd && upd_k < 0) upd_k = k;
    end
    chk({tag, "_rise_l"}, rise_l, 33);
    chk({tag, "_rise_r"}, rise_r, 33);
    chk({tag, "_pwm2_early"}, pwm2_early, 0);
    chk({tag, "_first_upd"}, upd_k, 2048);
  endtask

  initial begin
    rst_n    = 1'b0;
    lft_spd  = 11'd0;
    rght_spd = 11'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, upd}), 0);

    fresh_start("init");

    // spd = 0 on both motors: 992 / 991 high clocks, upd every 2048 clocks
    for (int p = 0; p < 3; p++) begin
      measure(-1, 11'd0);
      if (p > 0) chk("zero_upd_gap", wt, 1);
      check_period("zero", 992, 991, 992, 991);
    end

    // Reset asserted mid-period with spd = +300
    lft_spd  = 11'd300;
    rght_spd = 11'd300;
    measure(-1, 11'd300);
`ifndef MTR_SLEW_EN
    measure(-1, 11'd300);
    check_period("spd300", 1292, 691, 1292, 691);
`endif
    wt = 0;
    do begin
      @(negedge clk);
      wt++;
    end while (!upd && wt < 4200);
    chk("rst_mid_sync", int'(upd), 1);
    repeat (1300) @(negedge clk);
`ifndef MTR_SLEW_EN
    chk("pre_rst_l1", int'(lftPWM1), 1);
`endif
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_outs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, upd}), 0);
    lft_spd  = 11'd0;
    rght_spd = 11'd0;
    repeat (4) @(negedge clk);
    fresh_start("rerst");

`ifndef MTR_SLEW_EN
    // Extremes: d = 2047 on the left, d = 0 on the right
    lft_spd  = 11'd1023;
    rght_spd = 11'h400;
    measure(-1, 11'd1023);
    measure(-1, 11'd1023);
    check_period("extreme", 2015, 0, 0, 2015);

    // Mid-period change 0 -> +200 at cnt == 500 takes effect next period
    lft_spd  = 11'd0;
    rght_spd = 11'd0;
    measure(-1, 11'd0);
    measure(500, 11'd200);
    check_period("chg_cur", 992, 991, 992, 991);
    measure(-1, 11'd200);
    check_period("chg_nxt", 1192, 791, 992, 991);
`else
    // Slew-limited step 0 -> +400: +16 clocks per period until 1392
    measure(-1, 11'd0);
    measure(500, 11'd400);
    chk("slew_p0_l1", l1, 992);
    for (int n = 1; n <= 26; n++) begin
      measure(-1, 11'd400);
      chk($sformatf("slew_p%0d_l1", n), l1, (992 + 16 * n > 1392) ? 1392 : 992 + 16 * n);
      chk($sformatf("slew_p%0d_ovl", n), ovl, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
